// File: rtl/led_pattern_gen.sv
// LED pattern engine: bounce, rotate, count and Johnson bar patterns with a
// run-time step period, pause, and PWM brightness on registered LED outputs.
module led_pattern_gen #(
  parameter int LED_W   = 8,
  parameter int PRESC_W = 24,
  parameter int PWM_W   = 4
) (
  input  logic               OSC_50m,
  input  logic               FPGA_RSTn,
  input  logic [1:0]         mode_i,
  input  logic               mode_vld_i,
  input  logic [PRESC_W-1:0] speed_i,
  input  logic               pause_i,
  input  logic [PWM_W-1:0]   bright_i,
  output logic [LED_W-1:0]   USER_LED,
  output logic               tick_o,
  output logic               wrap_o
);

  localparam int POS_W = (LED_W > 2) ? $clog2(LED_W) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [LED_W-1:0]   pat_q, pat_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;

  logic               step;
  logic               period_end;
  logic               pwm_on;
  logic [LED_W-1:0]   cur_pat;

  // Prescaler: a mode load restarts the period, pause freezes it.
  always_comb begin
    step    = 1'b0;
    presc_d = presc_q;
    if (mode_vld_i) begin
      presc_d = '0;
    end else if (pause_i) begin
      presc_d = presc_q;
    end else if (presc_q >= speed_i) begin
      step    = 1'b1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Pattern state: restart on mode load, otherwise advance on each step.
  always_comb begin
    mode_d     = mode_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    pat_d      = pat_q;
    period_end = 1'b0;
    if (mode_vld_i) begin
      mode_d = mode_e'(mode_i);
      case (mode_e'(mode_i))
        MODE_BOUNCE: begin
          pos_d = '0;
          dir_d = DIR_UP;
        end
        MODE_ROTATE: pat_d = LED_W'(1);
        MODE_COUNT:  pat_d = '0;
        MODE_BAR:    pat_d = '0;
        default:     pat_d = '0;
      endcase
    end else if (step) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              dir_d = DIR_DOWN;
              pos_d = POS_MAX - POS_W'(1);
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
          // With LED_W=2 the 1->0 move happens on the turn at the top.
          period_end = (pos_q == POS_W'(1)) && (pos_d == '0);
        end
        MODE_ROTATE: begin
          pat_d      = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
          period_end = (pat_d == LED_W'(1));
        end
        MODE_COUNT: begin
          pat_d      = pat_q + LED_W'(1);
          period_end = (pat_d == '0);
        end
        MODE_BAR: begin
          pat_d      = {pat_q[LED_W-2:0], ~pat_q[LED_W-1]};
          period_end = (pat_d == '0);
        end
        default: begin
          pat_d      = pat_q;
          period_end = 1'b0;
        end
      endcase
    end else begin
      period_end = 1'b0;
    end
  end

  // Displayed pattern, PWM gating and output pulses.
  always_comb begin
    cur_pat = pat_q;
    case (mode_q)
      MODE_BOUNCE: cur_pat = LED_W'(1) << pos_q;
      MODE_ROTATE: cur_pat = pat_q;
      MODE_COUNT:  cur_pat = pat_q;
      MODE_BAR:    cur_pat = pat_q;
      default:     cur_pat = pat_q;
    endcase
    pwm_d  = pwm_q + PWM_W'(1);
    pwm_on = (pwm_q <= bright_i);
    if (pwm_on) begin
      led_d = cur_pat;
    end else begin
      led_d = '0;
    end
    tick_d = step;
    wrap_d = step & period_end;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge OSC_50m) begin
    if (!FPGA_RSTn) begin
      mode_q  <= MODE_BOUNCE;
      dir_q   <= DIR_UP;
      pos_q   <= '0;
      pat_q   <= '0;
      presc_q <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      pat_q   <= pat_d;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign USER_LED = led_q;
  assign tick_o   = tick_q;
  assign wrap_o   = wrap_q;

endmodule
